// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch sequencer.
package fetch_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] INSTR_NOP    = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/fetch_buf.sv
// Two-entry F/D skid: output entry OB feeds decode, SB catches one fetch while OB is held.
// Flush drops entries except one whose pc matches i_keep_pc when i_keep_en is set.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_pc,
  input  logic [31:0]       i_push_dat,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic              i_keep_en,
  input  logic [ADDR_W-1:0] i_keep_pc,
  output logic              o_ob_vld,
  output logic [ADDR_W-1:0] o_ob_pc,
  output logic [31:0]       o_ob_dat,
  output logic              o_sb_nxt_vld
);
  logic              r_ob_vld, r_sb_vld;
  logic [ADDR_W-1:0] r_ob_pc, r_sb_pc;
  logic [31:0]       r_ob_dat, r_sb_dat;

  logic              w_ob_keep, w_sb_keep;
  logic              w_ob_vld_n, w_sb_vld_n;
  logic [ADDR_W-1:0] w_ob_pc_n, w_sb_pc_n;
  logic [31:0]       w_ob_dat_n, w_sb_dat_n;

  assign w_ob_keep = r_ob_vld && !i_pop && !(i_flush && !(i_keep_en && r_ob_pc == i_keep_pc));
  assign w_sb_keep = r_sb_vld && !(i_flush && !(i_keep_en && r_sb_pc == i_keep_pc));

  // Surviving entries are packed oldest-first: OB, then SB, then the new push.
  always_comb begin
    w_ob_vld_n = r_ob_vld;
    w_ob_pc_n  = r_ob_pc;
    w_ob_dat_n = r_ob_dat;
    w_sb_vld_n = 1'b0;
    w_sb_pc_n  = r_sb_pc;
    w_sb_dat_n = r_sb_dat;
    if (w_ob_keep) begin
      w_ob_vld_n = 1'b1;
      if (w_sb_keep) begin
        w_sb_vld_n = 1'b1;
      end else if (i_push) begin
        w_sb_vld_n = 1'b1;
        w_sb_pc_n  = i_push_pc;
        w_sb_dat_n = i_push_dat;
      end
    end else if (w_sb_keep) begin
      w_ob_vld_n = 1'b1;
      w_ob_pc_n  = r_sb_pc;
      w_ob_dat_n = r_sb_dat;
      if (i_push) begin
        w_sb_vld_n = 1'b1;
        w_sb_pc_n  = i_push_pc;
        w_sb_dat_n = i_push_dat;
      end
    end else begin
      w_ob_vld_n = i_push;
      if (i_push) begin
        w_ob_pc_n  = i_push_pc;
        w_ob_dat_n = i_push_dat;
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ob_vld <= 1'b0;
      r_ob_pc  <= RESET_PC;
      r_ob_dat <= INSTR_NOP;
      r_sb_vld <= 1'b0;
      r_sb_pc  <= RESET_PC;
      r_sb_dat <= INSTR_NOP;
    end else begin
      r_ob_vld <= w_ob_vld_n;
      r_ob_pc  <= w_ob_pc_n;
      r_ob_dat <= w_ob_dat_n;
      r_sb_vld <= w_sb_vld_n;
      r_sb_pc  <= w_sb_pc_n;
      r_sb_dat <= w_sb_dat_n;
    end
  end

  assign o_ob_vld     = r_ob_vld;
  assign o_ob_pc      = r_ob_pc;
  assign o_ob_dat     = r_ob_dat;
  assign o_sb_nxt_vld = w_sb_vld_n;
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, drives a req/ack imem port, buffers into F/D, honours stall/redirect.
// DELAY_SLOT_EN keeps the MIPS delay slot across a redirect; undefined, redirects flush everything.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic [ADDR_W-1:0] pc_d,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              valid_f,
  output logic [31:0]       instr_f,
  output logic [ADDR_W-1:0] pc_f
);
  localparam logic [ADDR_W-1:0] LP_ALIGN    = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] LP_RESET_PC = RESET_PC & LP_ALIGN;

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc, r_tgt, r_pend_pc;
  logic              r_pend_vld;

  logic              w_keep_en, w_redir, w_ds_hit, w_push, w_pop, w_sb_nxt;
  logic [ADDR_W-1:0] w_tgt, w_ds;

`ifdef DELAY_SLOT_EN
  assign w_keep_en = 1'b1;
`else
  assign w_keep_en = 1'b0;
`endif

  assign w_redir  = redirect && !stall;
  assign w_tgt    = redirect_pc & LP_ALIGN;
  assign w_ds     = (pc_d & LP_ALIGN) + ADDR_W'(4);
  assign w_ds_hit = w_keep_en && (r_pc == w_ds);
  assign w_pop    = valid_f && !stall;
  // Ack data survives a same-cycle redirect only when it is the delay slot.
  assign w_push   = (r_state == REQ) && imem_ack && (!w_redir || w_ds_hit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_pc       <= LP_RESET_PC;
      r_tgt      <= LP_RESET_PC;
      r_pend_vld <= 1'b0;
      r_pend_pc  <= LP_RESET_PC;
    end else begin
      case (r_state)
        IDLE, HOLD: begin
          r_state <= (r_state == HOLD && w_sb_nxt) ? HOLD : REQ;
          if (w_redir) begin
            if (w_ds_hit) begin
              r_pend_vld <= 1'b1;
              r_pend_pc  <= w_tgt;
            end else begin
              r_pc       <= w_tgt;
              r_pend_vld <= 1'b0;
            end
          end
        end
        REQ: begin
          if (imem_ack) begin
            r_state <= w_sb_nxt ? HOLD : REQ;
            if (w_redir) begin
              r_pc       <= w_tgt;
              r_pend_vld <= 1'b0;
            end else if (r_pend_vld) begin
              r_pc       <= r_pend_pc;
              r_pend_vld <= 1'b0;
            end else begin
              r_pc <= r_pc + ADDR_W'(4);
            end
          end else if (w_redir) begin
            if (w_ds_hit) begin
              r_pend_vld <= 1'b1;
              r_pend_pc  <= w_tgt;
            end else begin
              r_tgt      <= w_tgt;
              r_pend_vld <= 1'b0;
              r_state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_redir) r_tgt <= w_tgt;
          if (imem_ack) begin
            r_pc    <= w_redir ? w_tgt : r_tgt;
            r_state <= REQ;
          end
        end
      endcase
    end
  end

  assign imem_req  = (r_state == REQ) || (r_state == DRAIN);
  assign imem_addr = r_pc;

  fetch_buf #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (LP_RESET_PC)
  ) u_buf (
    .clk          (clk),
    .i_rst_n      (reset),
    .i_push       (w_push),
    .i_push_pc    (r_pc),
    .i_push_dat   (imem_rdata),
    .i_pop        (w_pop),
    .i_flush      (w_redir),
    .i_keep_en    (w_keep_en),
    .i_keep_pc    (w_ds),
    .o_ob_vld     (valid_f),
    .o_ob_pc      (pc_f),
    .o_ob_dat     (instr_f),
    .o_sb_nxt_vld (w_sb_nxt)
  );
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl; memory returns addr ^ KEY as the instruction word.
module tb_fetch_ctrl;
  localparam logic [31:0] KEY = 32'hC0DE_0000;
`ifdef DELAY_SLOT_EN
  localparam logic DS = 1'b1;
`else
  localparam logic DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] pc_d = 32'h0;
  logic        imem_ack = 1'b0;
  logic        imem_req, valid_f;
  logic [31:0] imem_addr, imem_rdata, instr_f, pc_f;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ KEY;

  fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc_d        (pc_d),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .valid_f     (valid_f),
    .instr_f     (instr_f),
    .pc_f        (pc_f)
  );

  typedef struct {
    logic        stall;
    logic        redir;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input logic st, input logic rd, input logic ak, input logic rq,
                              input logic [31:0] ad, input logic vl, input logic [31:0] pc);
    vec_t v;
    v.stall = st; v.redir = rd; v.ack = ak;
    v.e_req = rq; v.e_addr = ad; v.e_vld = vl; v.e_pc = pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic e_vld, input logic [31:0] e_pc);
    chk({tag, ".req"}, 32'(imem_req), 32'(e_req));
    if (e_req) chk({tag, ".addr"}, imem_addr, e_addr);
    chk({tag, ".vld"}, 32'(valid_f), 32'(e_vld));
    if (e_vld) begin
      chk({tag, ".pc_f"}, pc_f, e_pc);
      chk({tag, ".instr_f"}, instr_f, e_pc ^ KEY);
    end
  endtask

  initial begin
    // zero-wait run, 4-cycle stall into HOLD, 3-cycle latency, stalled then live redirect
    tbl[0]  = mk(0, 0, 0, 0, 32'h3000, 0, 32'h0);
    tbl[1]  = mk(0, 0, 1, 1, 32'h3000, 0, 32'h0);
    tbl[2]  = mk(0, 0, 1, 1, 32'h3004, 1, 32'h3000);
    tbl[3]  = mk(0, 0, 1, 1, 32'h3008, 1, 32'h3004);
    tbl[4]  = mk(1, 0, 1, 1, 32'h300C, 1, 32'h3008);
    tbl[5]  = mk(1, 0, 0, 0, 32'h3010, 1, 32'h3008);
    tbl[6]  = mk(1, 0, 0, 0, 32'h3010, 1, 32'h3008);
    tbl[7]  = mk(1, 0, 0, 0, 32'h3010, 1, 32'h3008);
    tbl[8]  = mk(0, 0, 0, 0, 32'h3010, 1, 32'h3008);
    tbl[9]  = mk(0, 0, 0, 1, 32'h3010, 1, 32'h300C);
    tbl[10] = mk(0, 0, 0, 1, 32'h3010, 0, 32'h0);
    tbl[11] = mk(0, 0, 1, 1, 32'h3010, 0, 32'h0);
    tbl[12] = mk(0, 0, 0, 1, 32'h3014, 1, 32'h3010);
    tbl[13] = mk(0, 0, 0, 1, 32'h3014, 0, 32'h0);
    tbl[14] = mk(0, 0, 1, 1, 32'h3014, 0, 32'h0);
    tbl[15] = mk(1, 1, 0, 1, 32'h3018, 1, 32'h3014);
    tbl[16] = mk(0, 1, 0, 1, 32'h3018, 1, 32'h3014);
    tbl[17] = mk(0, 0, 0, 1, 32'h3018, 0, 32'h0);
    tbl[18] = mk(0, 0, 1, 1, 32'h3018, 0, 32'h0);
    tbl[19] = mk(0, 0, 1, 1, 32'h3100, 0, 32'h0);
    tbl[20] = mk(0, 0, 1, 1, 32'h3104, 1, 32'h3100);
    tbl[21] = mk(0, 0, 0, 1, 32'h3108, 1, 32'h3104);

    repeat (3) @(negedge clk);
    chk("reset.req", 32'(imem_req), 32'h0);
    chk("reset.vld", 32'(valid_f), 32'h0);
    chk("reset.pc_f", pc_f, 32'h3000);
    chk("reset.instr_f", instr_f, 32'h0);

    redirect_pc = 32'h3100;
    pc_d        = 32'h3010;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 22; i++) begin
      stall    = tbl[i].stall;
      redirect = tbl[i].redir;
      imem_ack = tbl[i].ack;
      #1;
      chk_out($sformatf("v%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld, tbl[i].e_pc);
      @(negedge clk);
    end

    // reset in the middle of an outstanding request, stale ack afterwards
    stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    chk("arst.req", 32'(imem_req), 32'h0);
    chk("arst.vld", 32'(valid_f), 32'h0);
    chk("arst.pc_f", pc_f, 32'h3000);
    imem_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_out("arst.idle", 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    chk_out("arst.c1", 1, 32'h3000, 0, 32'h0);
    @(negedge clk);
    #1;
    chk_out("arst.c2", 1, 32'h3000, 0, 32'h0);

    // redirect with same-cycle ack on a non-delay-slot address; target low bits forced off
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; pc_d = 32'h0000_8000; imem_ack = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk_out("wrap.c1", 1, 32'hFFFF_FFFC, 0, 32'h0);
    @(negedge clk);
    #1;
    chk_out("wrap.c2", 1, 32'h0000_0000, 1, 32'hFFFF_FFFC);

    // same-cycle ack for the delay slot (wrapped DS address 0)
    redirect = 1'b1; redirect_pc = 32'h0000_0200; pc_d = 32'hFFFF_FFFC; imem_ack = 1'b1;
    @(negedge clk);
    redirect_pc = 32'h0000_0400; pc_d = 32'h0000_01FC; imem_ack = 1'b0;
    #1;
    chk_out("ds.ack", 1, 32'h0000_0200, DS, 32'h0);
    // delay slot not yet acked: fetched first (retention) or drained (no retention)
    @(negedge clk);
    redirect = 1'b0; imem_ack = 1'b1;
    #1;
    chk_out("ds.pend", 1, 32'h0000_0200, 0, 32'h0);
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    chk_out("ds.tgt", 1, 32'h0000_0400, DS, 32'h0000_0200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
